instr_issue: RTL and testbench

INSTR_ISSUE -- requirements
Module: instr_issue

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/instr_fifo.sv | 50 +++++
 rtl/instr_issue.sv | 112 +++++++++++
 tb/tb_instr_issue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, control-FSM state encodings and the
// issue-FSM state type used by the instruction issue stage.
package cpu_pkg;

  localparam logic [3:0] OP_LOAD   = 4'h0;
  localparam logic [3:0] OP_MOV    = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_LDPC   = 4'h5;
  localparam logic [3:0] OP_BRANCH = 4'h6;
  localparam logic [3:0] OP_MAX    = 4'h6;

  localparam logic [3:0] S0 = 4'b0000;
  localparam logic [3:0] S1 = 4'b0001;

  typedef enum logic [1:0] {
    ISS_IDLE  = 2'd0,
    ISS_ISSUE = 2'd1,
    ISS_WAIT  = 2'd2
  } issue_state_e;

  function automatic logic is_legal_op(input logic [15:0] word);
    return word[15:12] <= OP_MAX;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH x W instruction FIFO with push/pop/flush. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [AW:0]  wr_d, rd_d;
  logic [W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_d = push_i ? wr_q + 1'b1 : wr_q;
    rd_d = rd_q;
    if (flush_i)    rd_d = wr_d;
    else if (pop_i) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage carries no reset; occupancy is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/instr_issue.sv
// Instruction issue stage: queues incoming words and hands one at a time to the
// control FSM. Optional opcode filtering is enabled by INSTR_ILLEGAL_FILTER_EN.
module instr_issue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        flush,
  input  logic [3:0]  state,
  output logic [15:0] instr,
  output logic        new_instr,
  output logic        busy,
  output logic [15:0] issue_cnt,
  output logic        illegal
);

  logic         rst_meta_q, rst_n_q;
  logic         fifo_full, fifo_empty, push, pop, head_legal;
  logic [15:0]  head;
  issue_state_e fsm_q;
  logic [15:0]  instr_q, cnt_q;
  logic         new_instr_q, busy_q;

  // Assert asynchronously, release two clk edges later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  assign din_ready = !fifo_full && !flush;
  assign push      = din_valid && din_ready;
  assign pop       = !fifo_empty && (state == S0) &&
                     ((fsm_q == ISS_IDLE) || (fsm_q == ISS_WAIT));

  instr_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n_q),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (din),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef INSTR_ILLEGAL_FILTER_EN
  logic illegal_q;

  assign head_legal = is_legal_op(head);

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q)                 illegal_q <= 1'b0;
    else if (pop && !head_legal)  illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign head_legal = 1'b1;
  assign illegal    = 1'b0;
`endif

  // WAIT shares the pop path with IDLE so a returning state==S0 issues at once.
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      fsm_q       <= ISS_IDLE;
      instr_q     <= 16'h0000;
      new_instr_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= 16'h0000;
    end else begin
      case (fsm_q)
        ISS_IDLE, ISS_WAIT: begin
          if (pop && head_legal) begin
            instr_q     <= head;
            new_instr_q <= 1'b1;
            busy_q      <= 1'b1;
            fsm_q       <= ISS_ISSUE;
          end else if (pop || (state == S0)) begin
            busy_q <= 1'b0;
            fsm_q  <= ISS_IDLE;
          end
        end
        ISS_ISSUE: begin
          new_instr_q <= 1'b0;
          cnt_q       <= cnt_q + 16'd1;
          fsm_q       <= ISS_WAIT;
        end
        default: begin
          busy_q <= 1'b0;
          fsm_q  <= ISS_IDLE;
        end
      endcase
    end
  end

  assign instr     = instr_q;
  assign new_instr = new_instr_q;
  assign busy      = busy_q;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed scenarios plus randomized traffic
// compared cycle by cycle with a queue-based reference model.
module tb_instr_issue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        flush = 1'b0;
  logic [3:0]  state = '0;
  logic [15:0] instr;
  logic        new_instr;
  logic        busy;
  logic [15:0] issue_cnt;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  logic [15:0] mq[$];
  bit          m_busy, m_strobe, m_illegal;
  logic [15:0] m_instr, m_cnt;

  instr_issue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .flush     (flush),
    .state     (state),
    .instr     (instr),
    .new_instr (new_instr),
    .busy      (busy),
    .issue_cnt (issue_cnt),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal_op(input logic [15:0] w);
`ifdef INSTR_ILLEGAL_FILTER_EN
    return w[15:12] <= 4'h6;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && !flush;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_busy = 0; m_strobe = 0; m_illegal = 0;
    m_instr = '0; m_cnt = '0;
  endtask

  // One rising edge of the reference: an issued word spends one cycle announced,
  // then executes until the control FSM reports state 0; a waiting head is taken
  // whenever the issuer is not in its announce cycle and state is 0.
  task automatic model_edge();
    bit          rdy;
    logic [15:0] h;
    rdy = m_ready();
    if (m_strobe) begin
      m_strobe = 0;
      m_cnt    = m_cnt + 16'd1;
    end else if (state == 4'd0 && mq.size() > 0) begin
      h = mq.pop_front();
      if (legal_op(h)) begin
        m_instr = h; m_strobe = 1; m_busy = 1;
      end else begin
        m_illegal = 1; m_busy = 0;
      end
    end else if (m_busy && state == 4'd0) begin
      m_busy = 0;
    end
    if (flush) mq.delete();
    if (din_valid && rdy) mq.push_back(din);
  endtask

  task automatic check_outputs();
    chk("instr",     instr,     m_instr);
    chk("new_instr", new_instr, m_strobe);
    chk("busy",      busy,      m_busy);
    chk("issue_cnt", issue_cnt, m_cnt);
    chk("illegal",   illegal,   m_illegal);
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic f, input logic [3:0] s);
    @(negedge clk);
    din = d; din_valid = v; flush = f; state = s;
    #1 chk("din_ready", din_ready, m_ready());
    @(posedge clk);
    model_edge();
    #1 check_outputs();
  endtask

  task automatic check_reset_values();
    chk("rst_instr",     instr,     16'h0000);
    chk("rst_new_instr", new_instr, 1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_issue_cnt", issue_cnt, 16'h0000);
    chk("rst_illegal",   illegal,   1'b0);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    check_reset_values();
    resetn = 1'b1;
    repeat (3) step(0, 16'h0, 0, 4'd0);
  endtask

  logic [15:0] cnt0;

  initial begin
    model_clear();
    #1 resetn = 1'b0;
    #1 check_reset_values();
    release_reset();

    // Single issue
    step(1, 16'h2123, 0, 4'd0);
    step(0, 16'h0, 0, 4'd0);
    chk("single_instr", instr, 16'h2123);
    chk("single_strobe", new_instr, 1'b1);
    step(0, 16'h0, 0, 4'd1);
    chk("single_strobe_drop", new_instr, 1'b0);
    step(0, 16'h0, 0, 4'd9);
    step(0, 16'h0, 0, 4'd10);
    step(0, 16'h0, 0, 4'd11);
    chk("single_busy", busy, 1'b1);
    step(0, 16'h0, 0, 4'd0);
    chk("single_idle", busy, 1'b0);
    chk("single_cnt", issue_cnt, 16'd1);

    // Back-to-back with a two-state load
    step(1, 16'h0001, 0, 4'd1);
    step(1, 16'h1002, 0, 4'd1);
    step(1, 16'h6003, 0, 4'd1);
    step(0, 16'h0, 0, 4'd0);
    step(0, 16'h0, 0, 4'd1);
    step(0, 16'h0, 0, 4'd2);
    step(0, 16'h0, 0, 4'd0);
    chk("b2b_second_strobe", new_instr, 1'b1);
    chk("b2b_second_instr", instr, 16'h1002);
    repeat (6) step(0, 16'h0, 0, 4'd0);

    // Full FIFO and pointer wrap
    for (int i = 0; i < 5; i++) step(1, {4'(i), 12'(16'h0A0 + i)}, 0, 4'd5);
    chk("full_ready", din_ready, 1'b0);
    repeat (12) step(0, 16'h0, 0, 4'd0);
    chk("full_drain_last", instr, {4'd3, 12'h0A3});

    // Flush while an instruction is in flight
    step(1, 16'h3001, 0, 4'd1);
    step(0, 16'h0, 0, 4'd0);
    step(1, 16'h4100, 0, 4'd1);
    step(1, 16'h4200, 0, 4'd1);
    step(1, 16'h4300, 0, 4'd1);
    step(1, 16'h5555, 1, 4'd1);
    chk("flush_instr", instr, 16'h3001);
    repeat (4) step(0, 16'h0, 0, 4'd0);
    chk("flush_no_issue", instr, 16'h3001);

    // Opcode filter
    cnt0 = m_cnt;
    step(1, 16'hF000, 0, 4'd1);
    step(1, 16'h1234, 0, 4'd1);
    repeat (6) step(0, 16'h0, 0, 4'd0);
    chk("filt_instr", instr, 16'h1234);
`ifdef INSTR_ILLEGAL_FILTER_EN
    chk("filt_illegal", illegal, 1'b1);
    chk("filt_cnt", issue_cnt, cnt0 + 16'd1);
`else
    chk("filt_illegal", illegal, 1'b0);
    chk("filt_cnt", issue_cnt, cnt0 + 16'd2);
`endif

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0);
    end

    // Reset in WAIT with two queued entries
    repeat (6) step(0, 16'h0, 0, 4'd0);
    step(1, 16'h2AAA, 0, 4'd0);
    step(0, 16'h0, 0, 4'd0);
    step(1, 16'h2BBB, 0, 4'd3);
    step(1, 16'h2CCC, 0, 4'd3);
    chk("pre_rst_busy", busy, 1'b1);
    @(negedge clk);
    din_valid = 1'b0; state = 4'd0;
    #2 resetn = 1'b0;
    #1 check_reset_values();
    model_clear();
    release_reset();
    repeat (4) step(0, 16'h0, 0, 4'd0);
    step(1, 16'h1777, 0, 4'd0);
    step(0, 16'h0, 0, 4'd0);
    chk("post_rst_issue", instr, 16'h1777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
